// File: rtl/reaction_timer_multi.sv
// Multi-round reaction timer: random arm delay from a free-running LFSR, tick-based
// timing with saturation, false-start detection, and per-session best/average results.
module reaction_timer_multi #(
  parameter int CLK_PER_TICK    = 50000,
  parameter int MAX_COUNT       = 9999,
  parameter int CNT_W           = 14,
  parameter int ROUNDS          = 4,
  parameter int LED_W           = 10,
  parameter int DELAY_MIN_TICKS = 1000,
  parameter int DELAY_MASK_W    = 11
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iSTART,
  input  logic                      iSTOP,
  output logic [LED_W-1:0]          oLEDS,
  output logic [CNT_W-1:0]          oTIMER,
  output logic [CNT_W-1:0]          oFINAL,
  output logic [CNT_W-1:0]          oBEST,
  output logic [CNT_W-1:0]          oAVG,
  output logic [$clog2(ROUNDS):0]   oROUND,
  output logic                      oFALSE_START,
  output logic [2:0]                oSTATE
);

  localparam int LOG_R = $clog2(ROUNDS);
  localparam int RND_W = LOG_R + 1;
  localparam int SUM_W = CNT_W + LOG_R;
  localparam int PS_W  = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam int DLY_W = $clog2(DELAY_MIN_TICKS + (1 << DELAY_MASK_W)) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_TIMING = 3'd2;
  localparam logic [2:0] S_SHOW   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_COUNT);
  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(CLK_PER_TICK - 1);
  localparam logic [DLY_W-1:0] DLY_MIN   = DLY_W'(DELAY_MIN_TICKS);
  localparam logic [RND_W-1:0] ROUNDS_C  = RND_W'(ROUNDS);
  localparam logic [15:0]      LFSR_SEED = 16'hACE1;
  localparam logic [15:0]      LFSR_TAPS = 16'hB400;

  logic [2:0]       r_state;
  logic [LED_W-1:0] r_leds;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_final;
  logic [CNT_W-1:0] r_best;
  logic [CNT_W-1:0] r_avg;
  logic [RND_W-1:0] r_round;
  logic             r_false_start;
  logic [PS_W-1:0]  r_presc;
  logic [DLY_W-1:0] r_dly_cnt;
  logic [DLY_W-1:0] r_dly_target;
  logic [SUM_W-1:0] r_sum;
  logic             r_start_q;
  logic             r_stop_q;
  logic [15:0]      r_lfsr;

  logic             w_start_rise;
  logic             w_stop_rise;
  logic             w_tick;
  logic             w_arm;
  logic             w_wait_done;
  logic             w_rec;
  logic             w_rec_fs;
  logic [CNT_W-1:0] w_rec_val;
  logic [DLY_W-1:0] w_dly_inc;
  logic [SUM_W-1:0] w_sum_new;
  logic [RND_W-1:0] w_round_new;
  logic             w_sess_end;
  logic [CNT_W-1:0] w_avg_new;
  logic [15:0]      w_lfsr_next;
  logic [LED_W-1:0] w_arm_leds;
  logic [LED_W-1:0] w_alt_leds;

  assign w_start_rise = iSTART & ~r_start_q;
  assign w_stop_rise  = iSTOP & ~r_stop_q;
  assign w_tick       = (r_presc == PS_LAST);
  assign w_dly_inc    = r_dly_cnt + DLY_W'(1);

  // Right-shifting Galois form of x^16+x^14+x^13+x^11; a non-zero seed never reaches zero.
  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);

  genvar gi;
  generate
    for (gi = 0; gi < LED_W; gi = gi + 1) begin : g_led
      assign w_arm_leds[gi] = ((gi < 3) || (gi >= LED_W - 3)) ? 1'b1 : 1'b0;
      assign w_alt_leds[gi] = (gi % 2 == 0) ? 1'b1 : 1'b0;
    end
  endgenerate

  assign w_sum_new   = r_sum + SUM_W'(w_rec_val);
  assign w_round_new = r_round + RND_W'(1);
  assign w_sess_end  = (w_round_new == ROUNDS_C);
  assign w_avg_new   = CNT_W'(w_sum_new >> LOG_R);

  // A stop press in WAIT wins over a delay expiring on the same cycle.
  always_comb begin
    w_arm       = 1'b0;
    w_wait_done = 1'b0;
    w_rec       = 1'b0;
    w_rec_fs    = 1'b0;
    w_rec_val   = r_timer;
    case (r_state)
      S_IDLE, S_SHOW, S_DONE: w_arm = w_start_rise;
      S_WAIT: begin
        if (w_stop_rise) begin
          w_rec     = 1'b1;
          w_rec_fs  = 1'b1;
          w_rec_val = MAX_C;
        end else if (w_tick && (w_dly_inc >= r_dly_target)) begin
          w_wait_done = 1'b1;
        end
      end
      S_TIMING: begin
        if (w_stop_rise || (r_timer >= MAX_C)) begin
          w_rec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      r_state       <= S_IDLE;
      r_leds        <= '0;
      r_timer       <= '0;
      r_final       <= MAX_C;
      r_best        <= MAX_C;
      r_avg         <= MAX_C;
      r_round       <= '0;
      r_false_start <= 1'b0;
      r_presc       <= '0;
      r_dly_cnt     <= '0;
      r_dly_target  <= '0;
      r_sum         <= '0;
      r_start_q     <= 1'b0;
      r_stop_q      <= 1'b0;
      r_lfsr        <= LFSR_SEED;
    end else begin
      r_lfsr    <= w_lfsr_next;
      r_start_q <= iSTART;
      r_stop_q  <= iSTOP;

      case (r_state)
        S_IDLE: begin
          r_leds  <= '0;
          r_timer <= '0;
        end
        S_WAIT: begin
          if (w_tick) begin
            r_presc   <= '0;
            r_dly_cnt <= w_dly_inc;
          end else begin
            r_presc <= r_presc + PS_W'(1);
          end
          if (w_wait_done) begin
            r_leds  <= '1;
            r_state <= S_TIMING;
          end
        end
        S_TIMING: begin
          if (w_tick) begin
            r_presc <= '0;
            if (!w_rec) begin
              r_timer <= r_timer + CNT_W'(1);
            end
          end else begin
            r_presc <= r_presc + PS_W'(1);
          end
        end
        S_SHOW, S_DONE: ;
        default: r_state <= S_IDLE;
      endcase

      // Round end: latch the result and fold it into the session statistics.
      if (w_rec) begin
        r_final       <= w_rec_val;
        r_false_start <= w_rec_fs;
        r_sum         <= w_sum_new;
        r_round       <= w_round_new;
        if (!w_rec_fs && (w_rec_val < r_best)) begin
          r_best <= w_rec_val;
        end
        if (w_sess_end) begin
          r_avg   <= w_avg_new;
          r_leds  <= w_alt_leds;
          r_state <= S_DONE;
        end else begin
          r_leds  <= '0;
          r_state <= S_SHOW;
        end
      end

      if (w_arm) begin
        if (r_state == S_DONE) begin
          r_round <= '0;
          r_sum   <= '0;
          r_best  <= MAX_C;
        end
        r_dly_target  <= DLY_MIN + DLY_W'(r_lfsr[DELAY_MASK_W-1:0]);
        r_presc       <= '0;
        r_dly_cnt     <= '0;
        r_timer       <= '0;
        r_false_start <= 1'b0;
        r_leds        <= w_arm_leds;
        r_state       <= S_WAIT;
      end
    end
  end

  assign oLEDS        = r_leds;
  assign oTIMER       = r_timer;
  assign oFINAL       = r_final;
  assign oBEST        = r_best;
  assign oAVG         = r_avg;
  assign oROUND       = r_round;
  assign oFALSE_START = r_false_start;
  assign oSTATE       = r_state;

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Randomized scoreboard bench for reaction_timer_multi: stimulus pushes expected round
// results computed from session-level rules; a monitor pops them at each round end.
module tb_reaction_timer_multi;

  localparam int CPT  = 4;
  localparam int MAXC = 99;
  localparam int CW   = 7;
  localparam int RN   = 2;
  localparam int LW   = 10;
  localparam int DMIN = 3;
  localparam int DMW  = 2;
  localparam int RW   = $clog2(RN) + 1;

  localparam int ARM_LEDS = 'b1110000111;
  localparam int ALT_LEDS = 'b0101010101;
  localparam int ALL_LEDS = 'b1111111111;

  logic          clk    = 1'b0;
  logic          clk_en = 1'b0;
  logic          rst    = 1'b0;
  logic          start  = 1'b0;
  logic          stop   = 1'b0;
  logic [LW-1:0] leds;
  logic [CW-1:0] timer;
  logic [CW-1:0] final_v;
  logic [CW-1:0] best;
  logic [CW-1:0] avg;
  logic [RW-1:0] round_v;
  logic          fs;
  logic [2:0]    state;

  reaction_timer_multi #(
    .CLK_PER_TICK(CPT), .MAX_COUNT(MAXC), .CNT_W(CW), .ROUNDS(RN),
    .LED_W(LW), .DELAY_MIN_TICKS(DMIN), .DELAY_MASK_W(DMW)
  ) dut (
    .iCLK(clk), .iRST(rst), .iSTART(start), .iSTOP(stop),
    .oLEDS(leds), .oTIMER(timer), .oFINAL(final_v), .oBEST(best), .oAVG(avg),
    .oROUND(round_v), .oFALSE_START(fs), .oSTATE(state)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference random source: the specified 16-bit Galois LFSR stepped once per clock.
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  typedef struct {
    int fin;
    int fs;
    int best;
    int rnd;
    int avg;
    int st;
    int maxt;
  } exp_t;

  exp_t sb[$];
  int   m_res[$];
  bit   m_fs[$];
  int   m_avg = MAXC;

  // Session model: results list; best = min of valid results, average = sum / ROUNDS.
  task automatic model_record(input int res, input bit f);
    exp_t e;
    int   total;
    int   b;
    m_res.push_back(res);
    m_fs.push_back(f);
    total = 0;
    b     = MAXC;
    foreach (m_res[i]) begin
      total += m_res[i];
      if (!m_fs[i] && m_res[i] < b) b = m_res[i];
    end
    if (m_res.size() == RN) begin
      m_avg = total / RN;
      e.st  = 4;
    end else begin
      e.st = 3;
    end
    e.fin  = res;
    e.fs   = f ? 1 : 0;
    e.best = b;
    e.rnd  = m_res.size();
    e.avg  = m_avg;
    e.maxt = f ? 0 : res;
    sb.push_back(e);
  endtask

  task automatic reset_checks(input string p);
    chk({p, "_state"}, int'(state), 0);
    chk({p, "_leds"}, int'(leds), 0);
    chk({p, "_timer"}, int'(timer), 0);
    chk({p, "_final"}, int'(final_v), MAXC);
    chk({p, "_best"}, int'(best), MAXC);
    chk({p, "_avg"}, int'(avg), MAXC);
    chk({p, "_round"}, int'(round_v), 0);
    chk({p, "_false_start"}, int'(fs), 0);
  endtask

  // Monitor: a transition from WAIT/TIMING into SHOW/SESSION_DONE is a round end.
  initial begin : monitor
    int   prev;
    int   maxt;
    exp_t e;
    prev = 0;
    maxt = 0;
    forever begin
      @(negedge clk);
      if (state == 3'd1) maxt = 0;
      else if (int'(timer) > maxt) maxt = int'(timer);
      if ((prev == 1 || prev == 2) && (state == 3'd3 || state == 3'd4)) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected_round_end: got state %0d, required no round end", state);
        end else begin
          e = sb.pop_front();
          $display("round_end final=%0d fs=%0d best=%0d round=%0d avg=%0d state=%0d",
                   final_v, fs, best, round_v, avg, state);
          chk("final", int'(final_v), e.fin);
          chk("false_start", int'(fs), e.fs);
          chk("best", int'(best), e.best);
          chk("round", int'(round_v), e.rnd);
          chk("avg", int'(avg), e.avg);
          chk("end_state", int'(state), e.st);
          chk("max_timer", maxt, e.maxt);
          if (e.st == 4) chk("leds_done", int'(leds), ALT_LEDS);
          else if (e.fs == 0) chk("leds_show", int'(leds), 0);
        end
      end
      prev = int'(state);
    end
  end

  // kind: 0 stop after n TIMING cycles, 1 false start at WAIT sample n (clamped to the
  // last WAIT cycle), 2 timeout, 3 asynchronous reset after n TIMING cycles.
  task automatic do_round(input int kind, input int n, input bit keep_stop);
    int target;
    int pos;
    int j;
    int k;
    bit from_done;
    @(negedge clk);
    from_done = (state == 3'd4);
    target    = DMIN + int'(m_lfsr[DMW-1:0]);
    if (from_done) begin
      m_res.delete();
      m_fs.delete();
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("arm_state", int'(state), 1);
    chk("arm_leds", int'(leds), ARM_LEDS);
    chk("arm_timer", int'(timer), 0);
    chk("arm_false_start", int'(fs), 0);
    if (from_done) begin
      chk("new_session_round", int'(round_v), 0);
      chk("new_session_best", int'(best), MAXC);
      chk("new_session_avg", int'(avg), m_avg);
    end
    pos = n;
    if (kind == 1 && pos > 4 * target - 1) pos = 4 * target - 1;

    j = 0;
    while (state == 3'd1 && j < 200) begin
      if (kind != 1 && j == 2) start = 1'b1;
      if (kind != 1 && j == 3) start = 1'b0;
      if (kind == 1 && j == pos) begin
        stop = 1'b1;
        model_record(MAXC, 1'b1);
      end
      @(negedge clk);
      j++;
    end
    if (kind == 1) begin
      chk("false_start_latency", j, pos + 1);
      if (!keep_stop) stop = 1'b0;
      return;
    end
    chk("wait_cycles", j, 4 * target);
    chk("timing_state", int'(state), 2);
    chk("timing_leds", int'(leds), ALL_LEDS);

    k = 0;
    while (state == 3'd2 && k < 1000) begin
      if (k == 0 && stop) stop = 1'b0;
      if (kind == 0 && k == n) begin
        stop = 1'b1;
        model_record(n / CPT, 1'b0);
      end
      if (kind == 2 && k == 0) model_record(MAXC, 1'b0);
      if (kind == 3 && k == n) begin
        #2 rst = 1'b1;
        #1 reset_checks("mid_reset");
        #1 rst = 1'b0;
        m_res.delete();
        m_fs.delete();
        m_avg = MAXC;
        return;
      end
      @(negedge clk);
      k++;
    end
    if (kind == 0) chk("stop_latency", k, n + 1);
    if (kind == 2) chk("timeout_cycles", k, MAXC * CPT + 1);
    if (!keep_stop) stop = 1'b0;
  endtask

  initial begin : stimulus
    #1 rst = 1'b1;
    #3 reset_checks("por");
    #2 rst = 1'b0;
    clk_en = 1'b1;
    repeat (3) @(negedge clk);

    do_round(0, 20, 1'b0);
    do_round(0, 36 + int'($urandom_range(0, 3)), 1'b0);

    do_round(1, int'($urandom_range(0, 11)), 1'b1);
    do_round(0, int'($urandom_range(1, 60)), 1'b0);

    do_round(2, 0, 1'b0);
    do_round(1, 1000, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int kd;
      kd = int'($urandom_range(0, 1));
      if (kd == 1) do_round(1, int'($urandom_range(0, 30)), 1'b0);
      else         do_round(0, int'($urandom_range(0, 60)), 1'b0);
    end

    do_round(3, int'($urandom_range(5, 30)), 1'b0);
    repeat (2) @(negedge clk);
    chk("idle_after_reset", int'(state), 0);
    do_round(0, int'($urandom_range(0, 60)), 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog: got no completion, required completion within time budget");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
